// File: rtl/cache_repl_pkg.sv
// cache_repl_pkg: shared types for the LRU replacement unit.
// Holds the FSM state enum, clog2 helper and age/way typedefs.
package cache_repl_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } repl_state_t;

  // Associativity is bounded to 16, so 4 bits cover any age/way.
  localparam int MAX_WAY_W = 4;

  typedef logic [MAX_WAY_W-1:0] age_t;
  typedef logic [MAX_WAY_W-1:0] way_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lru_victim_select.sv
// lru_victim_select: combinational victim choice for one set.
// In: ages, valid_mask, [lock_mask]. Out: way, was_invalid, [all_locked].
// Lock ports exist only when LRU_WAY_LOCK_EN is defined.
module lru_victim_select
  import cache_repl_pkg::*;
#(
  parameter int NUM_WAYS = 8,
  localparam int WAY_W = clog2(NUM_WAYS)
) (
  input  logic [WAY_W-1:0]    ages [NUM_WAYS],
  input  logic [NUM_WAYS-1:0] valid_mask,
`ifdef LRU_WAY_LOCK_EN
  input  logic [NUM_WAYS-1:0] lock_mask,
  output logic                all_locked,
`endif
  output logic [WAY_W-1:0]    way,
  output logic                was_invalid
);

  logic [NUM_WAYS-1:0] usable;
  logic                found;
  age_t                best;

`ifdef LRU_WAY_LOCK_EN
  assign usable     = ~lock_mask;
  assign all_locked = ~|usable;
`else
  assign usable = '1;
`endif

  // Invalid ways win (lowest index first); otherwise the
  // oldest usable way. With no lock this is the LRU way.
  always_comb begin
    way         = '0;
    was_invalid = 1'b0;
    found       = 1'b0;
    best        = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (!found && usable[i] && !valid_mask[i]) begin
        way         = WAY_W'(i);
        was_invalid = 1'b1;
        found       = 1'b1;
      end
    end
    if (!found) begin
      for (int i = 0; i < NUM_WAYS; i++) begin
        if (usable[i] && age_t'(ages[i]) >= best) begin
          best = age_t'(ages[i]);
          way  = WAY_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/lru_replacement_unit.sv
// lru_replacement_unit: per-set true-LRU ages with touch and victim ports.
// Ports: clk, rst, upd_*, vict_valid/index, valid_mask, vict_ready,
// vict_resp_valid, vict_way, vict_was_invalid; lock_mask/all_locked
// only when LRU_WAY_LOCK_EN is defined.
module lru_replacement_unit
  import cache_repl_pkg::*;
#(
  parameter int NUM_SETS = 64,
  parameter int NUM_WAYS = 8,
  localparam int IDX_W = clog2(NUM_SETS),
  localparam int WAY_W = clog2(NUM_WAYS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                upd_valid,
  input  logic [IDX_W-1:0]    upd_index,
  input  logic [WAY_W-1:0]    upd_way,
  input  logic                vict_valid,
  input  logic [IDX_W-1:0]    vict_index,
  input  logic [NUM_WAYS-1:0] valid_mask,
`ifdef LRU_WAY_LOCK_EN
  input  logic [NUM_WAYS-1:0] lock_mask,
  output logic                all_locked,
`endif
  output logic                vict_ready,
  output logic                vict_resp_valid,
  output logic [WAY_W-1:0]    vict_way,
  output logic                vict_was_invalid
);

  logic [WAY_W-1:0]    age_q [NUM_SETS][NUM_WAYS];
  repl_state_t         state_q;
  repl_state_t         state_d;
  logic [IDX_W-1:0]    idx_q;
  logic [NUM_WAYS-1:0] mask_q;
  logic                accept;
  logic                way_ok;
  logic                idx_ok;
  logic                upd_ok;
  logic                auto_en;
  logic [WAY_W-1:0]    sel_ages [NUM_WAYS];
  logic [WAY_W-1:0]    sel_way;
  logic                sel_inv;
  logic [WAY_W-1:0]    upd_ref;
  logic [WAY_W-1:0]    auto_ref;
  logic [WAY_W-1:0]    upd_row [NUM_WAYS];
  logic [WAY_W-1:0]    auto_row [NUM_WAYS];

`ifdef LRU_WAY_LOCK_EN
  logic [NUM_WAYS-1:0] lock_q;
  logic                sel_all_locked;
`endif

  assign accept = vict_valid && vict_ready;

  // Range checks only matter for non-power-of-two sizes.
  if (NUM_WAYS == (1 << WAY_W)) begin : g_way_full
    assign way_ok = 1'b1;
  end else begin : g_way_part
    assign way_ok = upd_way < WAY_W'(NUM_WAYS);
  end

  if (NUM_SETS == (1 << IDX_W)) begin : g_idx_full
    assign idx_ok = 1'b1;
  end else begin : g_idx_part
    assign idx_ok = upd_index < IDX_W'(NUM_SETS);
  end

  assign upd_ok = upd_valid && way_ok && idx_ok;

  // Explicit touch to the same set overrides allocation.
  always_comb begin
    auto_en = (state_q == ST_RESP)
           && !(upd_valid && upd_index == idx_q);
`ifdef LRU_WAY_LOCK_EN
    if (sel_all_locked) auto_en = 1'b0;
`endif
  end

  always_comb begin
    for (int i = 0; i < NUM_WAYS; i++) begin
      sel_ages[i] = age_q[idx_q][i];
    end
  end

  lru_victim_select #(
    .NUM_WAYS (NUM_WAYS)
  ) u_sel (
    .ages        (sel_ages),
    .valid_mask  (mask_q),
`ifdef LRU_WAY_LOCK_EN
    .lock_mask   (lock_q),
    .all_locked  (sel_all_locked),
`endif
    .way         (sel_way),
    .was_invalid (sel_inv)
  );

  assign upd_ref  = age_q[upd_index][upd_way];
  assign auto_ref = age_q[idx_q][sel_way];

  // Touch: younger ways age by one, touched way becomes MRU.
  always_comb begin
    for (int i = 0; i < NUM_WAYS; i++) begin
      upd_row[i] = age_q[upd_index][i];
      if (WAY_W'(i) == upd_way) begin
        upd_row[i] = '0;
      end else if (age_q[upd_index][i] < upd_ref) begin
        upd_row[i] = age_q[upd_index][i] + 1'b1;
      end
      auto_row[i] = age_q[idx_q][i];
      if (WAY_W'(i) == sel_way) begin
        auto_row[i] = '0;
      end else if (age_q[idx_q][i] < auto_ref) begin
        auto_row[i] = age_q[idx_q][i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          age_q[s][w] <= WAY_W'(NUM_WAYS - 1 - w);
        end
      end
    end else begin
      if (upd_ok) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          age_q[upd_index][w] <= upd_row[w];
        end
      end
      if (auto_en) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          age_q[idx_q][w] <= auto_row[w];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      mask_q <= '0;
`ifdef LRU_WAY_LOCK_EN
      lock_q <= '0;
`endif
    end else if (accept) begin
      idx_q  <= vict_index;
      mask_q <= valid_mask;
`ifdef LRU_WAY_LOCK_EN
      lock_q <= lock_mask;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (vict_valid) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    vict_ready       = 1'b0;
    vict_resp_valid  = 1'b0;
    vict_way         = '0;
    vict_was_invalid = 1'b0;
`ifdef LRU_WAY_LOCK_EN
    all_locked       = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: vict_ready = 1'b1;
      ST_RESP: begin
        vict_resp_valid  = 1'b1;
        vict_way         = sel_way;
        vict_was_invalid = sel_inv;
`ifdef LRU_WAY_LOCK_EN
        all_locked       = sel_all_locked;
`endif
      end
      default: vict_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_lru_replacement_unit.sv
// tb_lru_replacement_unit: scoreboard bench for lru_replacement_unit.
// Reference keeps a per-set recency list (front = MRU).
module tb_lru_replacement_unit;

  localparam int NS = 64;
  localparam int NW = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       upd_valid = 1'b0;
  logic [5:0] upd_index = '0;
  logic [2:0] upd_way = '0;
  logic       vict_valid = 1'b0;
  logic [5:0] vict_index = '0;
  logic [7:0] valid_mask = '1;
  logic [7:0] lock_mask = '0;
  logic       all_locked;
  logic       vict_ready;
  logic       vict_resp_valid;
  logic [2:0] vict_way;
  logic       vict_was_invalid;

  always #5 clk = ~clk;

  lru_replacement_unit #(
    .NUM_SETS (NS),
    .NUM_WAYS (NW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .upd_valid        (upd_valid),
    .upd_index        (upd_index),
    .upd_way          (upd_way),
    .vict_valid       (vict_valid),
    .vict_index       (vict_index),
    .valid_mask       (valid_mask),
`ifdef LRU_WAY_LOCK_EN
    .lock_mask        (lock_mask),
    .all_locked       (all_locked),
`endif
    .vict_ready       (vict_ready),
    .vict_resp_valid  (vict_resp_valid),
    .vict_way         (vict_way),
    .vict_was_invalid (vict_was_invalid)
  );

`ifndef LRU_WAY_LOCK_EN
  assign all_locked = 1'b0;
`endif

  typedef struct packed {
    logic [2:0] way;
    logic       inv;
    logic       al;
  } exp_t;

  int   tests = 0;
  int   fails = 0;
  int   rec [NS][$];
  exp_t sbq [$];
  exp_t e;
  bit   m_resp = 0;
  int   m_idx = 0;
  int   m_way = 0;
  bit   m_al = 0;
  int   nresp = 0;
  int   last_way = 0;
  bit   last_inv = 0;
  bit   last_al = 0;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", n, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      rec[s].delete();
      for (int w = NW - 1; w >= 0; w--) rec[s].push_back(w);
    end
    sbq.delete();
    m_resp = 0;
  endtask

  task automatic touch(input int s, input int w);
    for (int k = 0; k < rec[s].size(); k++) begin
      if (rec[s][k] == w) begin
        rec[s].delete(k);
        break;
      end
    end
    rec[s].push_front(w);
  endtask

  // Lowest usable invalid way, else least recent usable way.
  task automatic pick(input int s, input logic [7:0] m,
                      input logic [7:0] lk, output exp_t r);
    bit done;
    done = 0;
    r = '0;
    if (lk == 8'hFF) begin
      r.al = 1'b1;
      done = 1;
    end
    for (int i = 0; i < NW && !done; i++) begin
      if (!m[i] && !lk[i]) begin
        r.way = 3'(i);
        r.inv = 1'b1;
        done  = 1;
      end
    end
    for (int k = rec[s].size() - 1; k >= 0 && !done; k--) begin
      if (!lk[rec[s][k]]) begin
        r.way = 3'(rec[s][k]);
        done  = 1;
      end
    end
  endtask

  // Reference model, advanced on the same edges as the DUT.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_reset();
    end else if (m_resp) begin
      if (upd_valid) touch(int'(upd_index), int'(upd_way));
      if (!(upd_valid && int'(upd_index) == m_idx) && !m_al)
        touch(m_idx, m_way);
      m_resp = 0;
    end else begin
      if (upd_valid) touch(int'(upd_index), int'(upd_way));
      if (vict_valid) begin
        pick(int'(vict_index), valid_mask,
`ifdef LRU_WAY_LOCK_EN
             lock_mask,
`else
             8'h00,
`endif
             e);
        sbq.push_back(e);
        m_resp = 1;
        m_idx  = int'(vict_index);
        m_way  = int'(e.way);
        m_al   = e.al;
      end
    end
  end

  exp_t got;

  // Monitor: compare every cycle on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ready", 32'(vict_ready), 32'd1);
      chk("rst_resp", 32'(vict_resp_valid), 32'd0);
      chk("rst_way", 32'(vict_way), 32'd0);
      chk("rst_inv", 32'(vict_was_invalid), 32'd0);
    end else begin
      chk("ready", 32'(vict_ready), 32'(!m_resp));
      chk("resp_valid", 32'(vict_resp_valid), 32'(m_resp));
      if (vict_resp_valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_resp", 32'd1, 32'd0);
        end else begin
          got = sbq.pop_front();
          chk("vict_way", 32'(vict_way), 32'(got.way));
          chk("vict_inv", 32'(vict_was_invalid), 32'(got.inv));
`ifdef LRU_WAY_LOCK_EN
          chk("all_locked", 32'(all_locked), 32'(got.al));
`endif
        end
        last_way = int'(vict_way);
        last_inv = vict_was_invalid;
        last_al  = all_locked;
        nresp++;
      end else begin
        chk("idle_way", 32'(vict_way), 32'd0);
        chk("idle_inv", 32'(vict_was_invalid), 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic victim(input string n, input logic [5:0] idx,
                        input logic [7:0] m, input int ew,
                        input bit ei);
    int n0;
    n0 = nresp;
    vict_index = idx;
    valid_mask = m;
    vict_valid = 1'b1;
    step();
    vict_valid = 1'b0;
    for (int i = 0; i < 10 && nresp == n0; i++) step();
    if (nresp == n0) begin
      chk({n, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({n, "_way"}, 32'(last_way), 32'(ew));
      chk({n, "_inv"}, 32'(last_inv), 32'(ei));
    end
  endtask

  initial begin
    int n0;
    #1 rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    step();

    victim("after_reset", 6'd5, 8'hFF, 0, 0);

    for (int w = 0; w < NW; w++) begin
      upd_valid = 1'b1;
      upd_index = 6'd0;
      upd_way   = 3'(w);
      step();
    end
    upd_valid = 1'b0;
    victim("lru_order", 6'd0, 8'hFF, 0, 0);
    victim("auto_touch", 6'd0, 8'hFF, 1, 0);

    victim("invalid_pick", 6'd9, 8'hF3, 2, 1);

    // Held request: accepted every other cycle.
    n0 = nresp;
    vict_index = 6'd11;
    valid_mask = 8'hFF;
    vict_valid = 1'b1;
    chk("hold_rdy0", 32'(vict_ready), 32'd1);
    step();
    chk("hold_rdy1", 32'(vict_ready), 32'd0);
    chk("hold_rsp1", 32'(vict_resp_valid), 32'd1);
    step();
    chk("hold_rdy2", 32'(vict_ready), 32'd1);
    step();
    chk("hold_rdy3", 32'(vict_ready), 32'd0);
    chk("hold_rsp3", 32'(vict_resp_valid), 32'd1);
    vict_valid = 1'b0;
    step();
    chk("hold_count", 32'(nresp - n0), 32'd2);

    // Explicit touch in the RESP cycle cancels allocation.
    n0 = nresp;
    vict_index = 6'd2;
    valid_mask = 8'hFF;
    vict_valid = 1'b1;
    step();
    vict_valid = 1'b0;
    upd_valid  = 1'b1;
    upd_index  = 6'd2;
    upd_way    = 3'd3;
    step();
    upd_valid  = 1'b0;
    chk("same_idx_cnt", 32'(nresp - n0), 32'd1);
    chk("same_idx_way", 32'(last_way), 32'd0);
    victim("no_auto", 6'd2, 8'hFF, 0, 0);

`ifdef LRU_WAY_LOCK_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    lock_mask = 8'h01;
    victim("lock_one", 6'd4, 8'hFF, 1, 0);
    lock_mask = 8'hFF;
    victim("lock_all", 6'd4, 8'hFF, 0, 0);
    chk("lock_all_flag", 32'(last_al), 32'd1);
    lock_mask = 8'h00;
`endif

    // Reset during RESP drops the pending response.
    vict_index = 6'd3;
    valid_mask = 8'hFF;
    vict_valid = 1'b1;
    step();
    rst = 1'b1;
    vict_valid = 1'b0;
    n0 = nresp;
    step();
    rst = 1'b0;
    repeat (4) step();
    chk("rst_discard", 32'(nresp - n0), 32'd0);

    for (int c = 0; c < 3000; c++) begin
      upd_valid  = ($urandom_range(0, 1) == 1);
      upd_index  = 6'($urandom_range(0, 3));
      upd_way    = 3'($urandom_range(0, NW - 1));
      vict_valid = ($urandom_range(0, 9) < 4);
      vict_index = 6'($urandom_range(0, 3));
      valid_mask = ($urandom_range(0, 9) < 7) ? 8'hFF
                   : 8'($urandom);
`ifdef LRU_WAY_LOCK_EN
      lock_mask  = ($urandom_range(0, 9) < 7) ? 8'h00
                   : 8'($urandom);
`endif
      if (c % 97 == 0) upd_index = 6'($urandom_range(0, NS - 1));
      step();
    end
    upd_valid  = 1'b0;
    vict_valid = 1'b0;
    repeat (4) step();
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lru_replacement_unit.md
LRU_REPLACEMENT_UNIT -- requirements
Module: lru_replacement_unit

Interface
REQ-001 SHALL have parameter NUM_SETS, default 64: number of cache sets.
REQ-002 SHALL have parameter NUM_WAYS, default 8: associativity; legal values 2..16.
REQ-003 SHALL derive IDX_W = clog2(NUM_SETS) and WAY_W = clog2(NUM_WAYS); neither is user-overridable.
REQ-004 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port upd_valid, input, 1: touch request (hit/access).
REQ-007 SHALL have ports upd_index (input, IDX_W) and upd_way (input, WAY_W): set and way to touch.
REQ-008 SHALL have port vict_valid, input, 1: victim request.
REQ-009 SHALL have ports vict_index (input, IDX_W) and valid_mask (input, NUM_WAYS): set and its per-way valid bits, sampled at acceptance.
REQ-010 SHALL have port vict_ready, output, 1: request can be accepted.
REQ-011 SHALL have ports vict_resp_valid (output, 1), vict_way (output, WAY_W) and vict_was_invalid (output, 1).

Function
REQ-012 SHALL hold one age per way per set, WAY_W bits wide; age 0 = MRU, NUM_WAYS-1 = LRU; ages within a set are always a permutation of 0..NUM_WAYS-1.
REQ-013 Touch of way w: ways with age < age[w] increment, age[w] becomes 0; committed at the clock edge where upd_valid=1.
REQ-014 SHALL ignore a touch with upd_way >= NUM_WAYS or upd_index >= NUM_SETS.
REQ-015 FSM states IDLE and RESP; IDLE->RESP on vict_valid && vict_ready; RESP->IDLE unconditionally after one cycle.
REQ-016 vict_ready = 1 in IDLE only; vict_valid in RESP is not accepted and must be held by the requester.
REQ-017 Latency: request accepted in cycle N -> vict_resp_valid = 1 for exactly cycle N+1.
REQ-018 Selection: lowest-numbered way with valid_mask bit 0 (vict_was_invalid = 1); otherwise the way with age NUM_WAYS-1 (vict_was_invalid = 0).
REQ-019 Ages used for selection SHALL include every touch committed up to and including edge N.
REQ-020 In the RESP cycle the selected way SHALL be auto-touched (allocation makes it MRU).
REQ-021 If upd_valid targets the same index in the RESP cycle, the explicit touch SHALL be applied and the auto-touch dropped; a touch to a different index proceeds alongside the auto-touch.
REQ-022 vict_way and vict_was_invalid SHALL be 0 whenever vict_resp_valid = 0.

Reset
REQ-023 On rst: FSM = IDLE, vict_ready = 1, vict_resp_valid = 0, vict_way = 0, vict_was_invalid = 0, and every set has age[w] = NUM_WAYS-1-w (way NUM_WAYS-1 is MRU, way 0 is LRU).
REQ-024 Reset asserted mid-request SHALL discard the request; no response is produced after reset releases.

Configuration
REQ-025 Macro LRU_WAY_LOCK_EN: when defined, input lock_mask (NUM_WAYS) and output all_locked (1) SHALL exist. Locked ways are never selected, even if invalid. The victim is the lowest unlocked invalid way, else the unlocked way with the highest age. If all ways are locked: vict_way = 0, all_locked = 1 with vict_resp_valid, and no auto-touch.
REQ-026 Without LRU_WAY_LOCK_EN, lock_mask and all_locked SHALL be absent and behaviour SHALL be exactly REQ-018.

Structure
REQ-027 Package cache_repl_pkg SHALL hold the FSM state enum, the clog2 helper and the age/way width typedefs.
REQ-028 Combinational victim selection SHALL live in sub-module lru_victim_select (inputs: ages, valid_mask, optional lock_mask; outputs: way, was_invalid, all_locked).

Verification
REQ-029 After reset, victim request for index 5 with valid_mask 8'hFF -> one cycle later vict_way = 7? No: vict_way = 0, vict_was_invalid = 0, vict_resp_valid high for 1 cycle.
REQ-030 Touch ways 0..7 in order on index 0, then victim request with mask 8'hFF -> vict_way = 0; a repeat request -> vict_way = 1 (way 0 was auto-touched).
REQ-031 valid_mask 8'hF3 -> vict_way = 2, vict_was_invalid = 1.
REQ-032 vict_valid held for 3 cycles from IDLE -> accepted in cycles 0 and 2, vict_ready low in cycles 1 and 3, responses in cycles 1 and 3.
REQ-033 In the RESP cycle for index 2 (victim way 0), touch index 2 way 3 -> way 3 is MRU and way 0 is not auto-touched; a following victim request -> vict_way = 0.
REQ-034 With LRU_WAY_LOCK_EN after reset: lock_mask 8'h01, mask 8'hFF -> vict_way = 1; lock_mask 8'hFF -> all_locked = 1, vict_way = 0.
